// File: rtl/demux_stream_1_n.sv
// Registered 1:N valid/ready stream demultiplexer with broadcast mode and a saturating drop counter.
// Latency: one cycle from an accepted beat to o_valid on the target channel(s); o_err also one cycle later.
// Backpressure: o_ready follows the addressed slot (all slots for broadcast); an out-of-range select never stalls.
module demux_stream_1_n #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  parameter int SEL_W  = $clog2(N_OUT),
  parameter int CNT_W  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_W-1:0]       i_data,
  input  logic [SEL_W-1:0]        i_sel,
  input  logic                    i_bcast,
  output logic [N_OUT-1:0]        o_valid,
  input  logic [N_OUT-1:0]        i_ready,
  output logic [N_OUT*DATA_W-1:0] o_data,
  output logic                    o_err,
  output logic [CNT_W-1:0]        o_drop_cnt
);

  // With a power-of-two channel count every select value names a real channel.
  localparam bit SEL_POW2 = ((1 << SEL_W) == N_OUT);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t      slot_st [N_OUT];
  logic [N_OUT-1:0] avail;
  logic [N_OUT-1:0] load;
  logic             sel_ok;
  logic             sel_avail;
  logic             fire;
  logic             drop;

  // Valid mirrors the slot state; a slot can take a beat when empty or being drained this cycle.
  always_comb begin
    o_valid = '0;
    avail   = '0;
    for (int k = 0; k < N_OUT; k++) begin
      o_valid[k] = (slot_st[k] == FULL);
      avail[k]   = (slot_st[k] == EMPTY) | i_ready[k];
    end
  end

  generate
    if (SEL_POW2) begin : g_sel_full
      assign sel_ok = 1'b1;
    end else begin : g_sel_part
      assign sel_ok = ({1'b0, i_sel} < (SEL_W+1)'(N_OUT));
    end
  endgenerate

  // Availability of the unicast target, looked up without indexing past N_OUT.
  always_comb begin
    sel_avail = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (i_sel == SEL_W'(k)) sel_avail = avail[k];
    end
  end

  // Broadcast waits for every slot; a bad select is accepted and thrown away.
  assign o_ready = i_bcast ? (&avail) : (sel_ok ? sel_avail : 1'b1);
  assign fire    = i_valid & o_ready;
  assign drop    = fire & ~i_bcast & ~sel_ok;

  // Per-slot load strobes for the current transfer.
  always_comb begin
    load = '0;
    for (int k = 0; k < N_OUT; k++) begin
      load[k] = fire & (i_bcast | (sel_ok & (i_sel == SEL_W'(k))));
    end
  end

  // Slot FSMs: a load wins over a drain so back-to-back beats keep the slot FULL.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N_OUT; k++) slot_st[k] <= EMPTY;
      o_data <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (load[k]) begin
          slot_st[k]                   <= FULL;
          o_data[k*DATA_W +: DATA_W]   <= i_data;
        end else if (i_ready[k]) begin
          slot_st[k] <= EMPTY;
        end
      end
    end
  end

  // Error pulse and saturating count of dropped beats; both stay zero when drop is constant 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err      <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      o_err <= drop;
      if (drop && (o_drop_cnt != {CNT_W{1'b1}})) o_drop_cnt <= o_drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_stream_1_n.sv
module tb_demux_stream_1_n;

  logic        clk;
  logic        rst_n;

  logic        v8, r8, bc8, err8;
  logic [7:0]  d8, ov8, ir8, cnt8;
  logic [2:0]  sel8;
  logic [63:0] od8;

  logic        v6, r6, bc6, err6;
  logic [7:0]  d6, cnt6;
  logic [5:0]  ov6, ir6;
  logic [2:0]  sel6;
  logic [47:0] od6;

  int checks = 0;
  int errors = 0;

  demux_stream_1_n #(.DATA_W(8), .N_OUT(8), .CNT_W(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8), .o_ready(r8), .i_data(d8),
    .i_sel(sel8), .i_bcast(bc8), .o_valid(ov8), .i_ready(ir8), .o_data(od8),
    .o_err(err8), .o_drop_cnt(cnt8)
  );

  demux_stream_1_n #(.DATA_W(8), .N_OUT(6), .CNT_W(8)) dut6 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v6), .o_ready(r6), .i_data(d6),
    .i_sel(sel6), .i_bcast(bc6), .o_valid(ov6), .i_ready(ir6), .o_data(od6),
    .o_err(err6), .o_drop_cnt(cnt6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0;
    v8 = 1'b1; sel8 = 3'd0; d8 = 8'hEE; bc8 = 1'b0; ir8 = 8'h00;
    v6 = 1'b1; sel6 = 3'd7; d6 = 8'hEE; bc6 = 1'b0; ir6 = 6'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ov8 !== 8'h00) begin errors++; $display("FAIL reset_valid8: got %h expected 00", ov8); end
    checks++; if (od8 !== 64'h0) begin errors++; $display("FAIL reset_data8: got %h expected 0", od8); end
    checks++; if (r8 !== 1'b1) begin errors++; $display("FAIL reset_ready8: got %b expected 1", r8); end
    checks++; if (cnt8 !== 8'd0) begin errors++; $display("FAIL reset_cnt8: got %0d expected 0", cnt8); end
    checks++; if (err8 !== 1'b0) begin errors++; $display("FAIL reset_err8: got %b expected 0", err8); end
    checks++; if (ov6 !== 6'h00) begin errors++; $display("FAIL reset_valid6: got %h expected 00", ov6); end
    checks++; if (cnt6 !== 8'd0) begin errors++; $display("FAIL reset_cnt6: got %0d expected 0", cnt6); end
    checks++; if (err6 !== 1'b0) begin errors++; $display("FAIL reset_err6: got %b expected 0", err6); end
    v8 = 1'b0; v6 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unicast_sweep;
    ir8 = 8'hFF; bc8 = 1'b0; v8 = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel8 = 3'(s);
      d8   = 8'hA0 + 8'(s);
      #1;
      checks++; if (r8 !== 1'b1) begin errors++; $display("FAIL sweep_ready sel=%0d: got %b expected 1", s, r8); end
      @(posedge clk);
      #1;
      checks++; if (ov8 !== (8'h01 << s)) begin errors++; $display("FAIL sweep_valid sel=%0d: got %h expected %h", s, ov8, 8'h01 << s); end
      checks++; if (od8[s*8 +: 8] !== 8'hA0 + 8'(s)) begin errors++; $display("FAIL sweep_data sel=%0d: got %h expected %h", s, od8[s*8 +: 8], 8'hA0 + 8'(s)); end
    end
    v8 = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (ov8 !== 8'h00) begin errors++; $display("FAIL sweep_drained: got %h expected 00", ov8); end
  endtask

  task automatic test_backpressure;
    ir8 = 8'hF7; v8 = 1'b1; sel8 = 3'd3; d8 = 8'h31;
    #1;
    checks++; if (r8 !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b expected 1", r8); end
    @(posedge clk);
    #1;
    checks++; if (ov8 !== 8'h08) begin errors++; $display("FAIL bp_first_valid: got %h expected 08", ov8); end
    d8 = 8'h32;
    #1;
    checks++; if (r8 !== 1'b0) begin errors++; $display("FAIL bp_second_stalled: got %b expected 0", r8); end
    @(posedge clk);
    #1;
    checks++; if (od8[24 +: 8] !== 8'h31) begin errors++; $display("FAIL bp_hold_data: got %h expected 31", od8[24 +: 8]); end
    sel8 = 3'd5; d8 = 8'h55;
    #1;
    checks++; if (r8 !== 1'b1) begin errors++; $display("FAIL bp_other_ready: got %b expected 1", r8); end
    @(posedge clk);
    #1;
    checks++; if (ov8 !== 8'h28) begin errors++; $display("FAIL bp_other_valid: got %h expected 28", ov8); end
    checks++; if (od8[40 +: 8] !== 8'h55) begin errors++; $display("FAIL bp_other_data: got %h expected 55", od8[40 +: 8]); end
    sel8 = 3'd3; d8 = 8'h32; ir8 = 8'hFF;
    #1;
    checks++; if (r8 !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", r8); end
    @(posedge clk);
    #1;
    checks++; if (ov8 !== 8'h08) begin errors++; $display("FAIL bp_b2b_valid: got %h expected 08", ov8); end
    checks++; if (od8[24 +: 8] !== 8'h32) begin errors++; $display("FAIL bp_b2b_data: got %h expected 32", od8[24 +: 8]); end
    v8 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_broadcast;
    ir8 = 8'hBF; v8 = 1'b1; bc8 = 1'b0; sel8 = 3'd6; d8 = 8'h66;
    @(posedge clk);
    #1;
    checks++; if (ov8 !== 8'h40) begin errors++; $display("FAIL bc_slot6_full: got %h expected 40", ov8); end
    bc8 = 1'b1; sel8 = 3'd0; d8 = 8'h5A;
    #1;
    checks++; if (r8 !== 1'b0) begin errors++; $display("FAIL bc_blocked_ready: got %b expected 0", r8); end
    @(posedge clk);
    #1;
    checks++; if (ov8 !== 8'h40) begin errors++; $display("FAIL bc_blocked_valid: got %h expected 40", ov8); end
    checks++; if (od8[48 +: 8] !== 8'h66) begin errors++; $display("FAIL bc_blocked_data: got %h expected 66", od8[48 +: 8]); end
    ir8 = 8'hFF;
    #1;
    checks++; if (r8 !== 1'b1) begin errors++; $display("FAIL bc_release_ready: got %b expected 1", r8); end
    @(posedge clk);
    #1;
    checks++; if (ov8 !== 8'hFF) begin errors++; $display("FAIL bc_all_valid: got %h expected ff", ov8); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (od8[k*8 +: 8] !== 8'h5A) begin errors++; $display("FAIL bc_data ch=%0d: got %h expected 5a", k, od8[k*8 +: 8]); end
    end
    v8 = 1'b0; bc8 = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (ov8 !== 8'h00) begin errors++; $display("FAIL bc_drained: got %h expected 00", ov8); end
  endtask

  task automatic test_invalid_sel;
    int exp_cnt;
    ir6 = 6'h3F; bc6 = 1'b0; v6 = 1'b1; sel6 = 3'd5; d6 = 8'h5F;
    @(posedge clk);
    #1;
    checks++; if (ov6 !== 6'h20) begin errors++; $display("FAIL inv_legal_valid: got %h expected 20", ov6); end
    checks++; if (od6[40 +: 8] !== 8'h5F) begin errors++; $display("FAIL inv_legal_data: got %h expected 5f", od6[40 +: 8]); end
    checks++; if (err6 !== 1'b0) begin errors++; $display("FAIL inv_legal_err: got %b expected 0", err6); end
    for (int i = 1; i <= 300; i++) begin
      sel6 = (i == 1) ? 3'd6 : 3'd7;
      d6   = 8'(i);
      #1;
      checks++; if (r6 !== 1'b1) begin errors++; $display("FAIL inv_ready i=%0d: got %b expected 1", i, r6); end
      @(posedge clk);
      #1;
      exp_cnt = (i > 255) ? 255 : i;
      checks++; if (err6 !== 1'b1) begin errors++; $display("FAIL inv_err i=%0d: got %b expected 1", i, err6); end
      checks++; if (ov6 !== 6'h00) begin errors++; $display("FAIL inv_valid i=%0d: got %h expected 00", i, ov6); end
      checks++; if (cnt6 !== 8'(exp_cnt)) begin errors++; $display("FAIL inv_cnt i=%0d: got %0d expected %0d", i, cnt6, exp_cnt); end
    end
    v6 = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (err6 !== 1'b0) begin errors++; $display("FAIL inv_err_clear: got %b expected 0", err6); end
    checks++; if (cnt6 !== 8'd255) begin errors++; $display("FAIL inv_cnt_hold: got %0d expected 255", cnt6); end
    checks++; if (err8 !== 1'b0) begin errors++; $display("FAIL pow2_err_tied: got %b expected 0", err8); end
  endtask

  task automatic test_mid_reset;
    ir8 = 8'h00; bc8 = 1'b0; v8 = 1'b1; sel8 = 3'd1; d8 = 8'h11;
    @(posedge clk);
    #1;
    sel8 = 3'd4; d8 = 8'h44;
    @(posedge clk);
    #1;
    v8 = 1'b0;
    checks++; if (ov8 !== 8'h12) begin errors++; $display("FAIL mr_pre_valid: got %h expected 12", ov8); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ov8 !== 8'h00) begin errors++; $display("FAIL mr_async_valid: got %h expected 00", ov8); end
    checks++; if (od8 !== 64'h0) begin errors++; $display("FAIL mr_async_data: got %h expected 0", od8); end
    checks++; if (cnt6 !== 8'd0) begin errors++; $display("FAIL mr_async_cnt6: got %0d expected 0", cnt6); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (ov8 !== 8'h00) begin errors++; $display("FAIL mr_post_valid: got %h expected 00", ov8); end
    sel8 = 3'd1;
    #1;
    checks++; if (r8 !== 1'b1) begin errors++; $display("FAIL mr_post_ready: got %b expected 1", r8); end
    v8 = 1'b1; sel8 = 3'd4; d8 = 8'h77;
    @(posedge clk);
    #1;
    v8 = 1'b0;
    checks++; if (ov8 !== 8'h10) begin errors++; $display("FAIL mr_reload_valid: got %h expected 10", ov8); end
    checks++; if (od8[32 +: 8] !== 8'h77) begin errors++; $display("FAIL mr_reload_data: got %h expected 77", od8[32 +: 8]); end
  endtask

  initial begin
    test_reset();
    test_unicast_sweep();
    test_backpressure();
    test_broadcast();
    test_invalid_sel();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
